// File: rtl/soc_boot_ctrl.sv
// Boot / programmer-mode controller: synchronises and debounces the mode pin,
// sequences core and programmer resets, and routes UART RX and QSPI pad direction.
module soc_boot_ctrl #(
   parameter int unsigned NUM_UART          = 2,
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned DEBOUNCE_CYCLES   = 1024,
   parameter int unsigned RESET_HOLD_CYCLES = 16,
   parameter int unsigned QSPI_WIDTH        = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  programmer_mode_i,
   input  logic [NUM_UART-1:0]   uart_rx_i,
   output logic [NUM_UART-1:0]   core_uart_rx_o,
   output logic                  programmer_rx_o,
   output logic                  core_reset_no,
   output logic                  programmer_reset_no,
   output logic                  programmer_enable_o,
   output logic                  busy_o,
   output logic [1:0]            state_o,
   input  logic [QSPI_WIDTH-1:0] qspi_oen_i,
   output logic [QSPI_WIDTH-1:0] qspi_pad_oen_o
);

   localparam int unsigned HW = $clog2(RESET_HOLD_CYCLES + 1);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RST_HOLD    = 2'd0,
      CORE_RUN    = 2'd1,
      PROG_RUN    = 2'd2,
      SWITCH_HOLD = 2'd3
   } state_e;

   logic [SYNC_STAGES-1:0]               mode_sync_q;
   logic [SYNC_STAGES-1:0][NUM_UART-1:0] rx_sync_q;
   logic                                 mode_sync;
   logic [NUM_UART-1:0]                  rx_sync;

   logic          mode_q, mode_d;
   logic [DW-1:0] deb_q, deb_d;
   state_e        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          target_prog_q, target_prog_d;

   logic core_reset_q, prog_reset_q, prog_en_q, busy_q;

   logic [NUM_UART-1:0] core_rx;
   logic                prog_rx;

   assign mode_sync = mode_sync_q[SYNC_STAGES-1];
   assign rx_sync   = rx_sync_q[SYNC_STAGES-1];

   // Accept a new mode only after it has differed from the current one for a full window.
   always_comb begin
      mode_d = mode_q;
      deb_d  = '0;
      if (mode_sync != mode_q) begin
         if (deb_q == DEB_LAST) begin
            mode_d = mode_sync;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      hold_d        = hold_q;
      target_prog_d = target_prog_q;
      case (state_q)
         RST_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = CORE_RUN;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         CORE_RUN: begin
            if (mode_q) begin
               state_d       = SWITCH_HOLD;
               target_prog_d = 1'b1;
            end
         end
         PROG_RUN: begin
            if (!mode_q) begin
               state_d       = SWITCH_HOLD;
               target_prog_d = 1'b0;
            end
         end
         SWITCH_HOLD: begin
            if (hold_q == HOLD_LAST) begin
               state_d = target_prog_q ? PROG_RUN : CORE_RUN;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = RST_HOLD;
      endcase
   end

   // Outputs are decoded from the next state so they move on the same edge as state_q.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         mode_sync_q   <= '0;
         rx_sync_q     <= '1;
         mode_q        <= 1'b0;
         deb_q         <= '0;
         state_q       <= RST_HOLD;
         hold_q        <= '0;
         target_prog_q <= 1'b0;
         core_reset_q  <= 1'b0;
         prog_reset_q  <= 1'b0;
         prog_en_q     <= 1'b0;
         busy_q        <= 1'b1;
      end else begin
         mode_sync_q   <= {mode_sync_q[SYNC_STAGES-2:0], programmer_mode_i};
         rx_sync_q     <= {rx_sync_q[SYNC_STAGES-2:0], uart_rx_i};
         mode_q        <= mode_d;
         deb_q         <= deb_d;
         state_q       <= state_d;
         hold_q        <= hold_d;
         target_prog_q <= target_prog_d;
         core_reset_q  <= (state_d == CORE_RUN);
         prog_reset_q  <= (state_d == PROG_RUN);
         prog_en_q     <= (state_d == PROG_RUN);
         busy_q        <= (state_d == RST_HOLD) || (state_d == SWITCH_HOLD);
      end
   end

   // Channel 0 goes to exactly one consumer; idle-high whenever it belongs to neither.
   always_comb begin
      core_rx = rx_sync;
      prog_rx = 1'b1;
      case (state_q)
         PROG_RUN: begin
            core_rx[0] = 1'b1;
            prog_rx    = rx_sync[0];
         end
         SWITCH_HOLD: core_rx[0] = 1'b1;
         default: ;
      endcase
   end

   assign core_uart_rx_o      = core_rx;
   assign programmer_rx_o     = prog_rx;
   assign core_reset_no       = core_reset_q;
   assign programmer_reset_no = prog_reset_q;
   assign programmer_enable_o = prog_en_q;
   assign busy_o              = busy_q;
   assign state_o             = state_q;
   assign qspi_pad_oen_o      = core_reset_q ? qspi_oen_i : '1;

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// Bench for soc_boot_ctrl: reset-release vector table, directed mode-switch
// sequences and a randomized run against a cycle-stamped reference model.
module tb_soc_boot_ctrl;

   localparam int SYNC = 2;
   localparam int DEB  = 8;
   localparam int HOLD = 4;

   logic       clk;
   logic       reset_n;
   logic       mode_pin;
   logic [1:0] uart_rx;
   logic [3:0] qspi_oen;
   logic [1:0] core_rx;
   logic       prog_rx;
   logic       core_rst_n;
   logic       prog_rst_n;
   logic       prog_en;
   logic       busy;
   logic [1:0] state;
   logic [3:0] qspi_pad;

   int n_cmp = 0;
   int n_err = 0;

   soc_boot_ctrl #(
      .NUM_UART(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
      .RESET_HOLD_CYCLES(HOLD), .QSPI_WIDTH(4)
   ) dut (
      .clk_i(clk), .reset_ni(reset_n), .programmer_mode_i(mode_pin),
      .uart_rx_i(uart_rx), .core_uart_rx_o(core_rx), .programmer_rx_o(prog_rx),
      .core_reset_no(core_rst_n), .programmer_reset_no(prog_rst_n),
      .programmer_enable_o(prog_en), .busy_o(busy), .state_o(state),
      .qspi_oen_i(qspi_oen), .qspi_pad_oen_o(qspi_pad)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: delay lines as queues, holds timed by edge stamps
   int         m_edge    = 0;
   int         m_state   = 0;
   int         m_entered = 0;
   bit         m_mode    = 0;
   bit         m_target  = 0;
   bit         mpipe[$];
   logic [1:0] rpipe[$];
   bit         shist[$];

   task automatic model_reset_pipes();
      mpipe.delete();
      rpipe.delete();
      shist.delete();
      for (int i = 0; i < SYNC; i++) begin
         mpipe.push_back(1'b0);
         rpipe.push_back(2'b11);
      end
   endtask

   task automatic model_step();
      bit old_sync;
      bit old_mode;
      bit all_diff;
      m_edge++;
      if (!reset_n) begin
         m_state   = 0;
         m_entered = m_edge;
         m_mode    = 1'b0;
         model_reset_pipes();
         return;
      end
      old_sync = mpipe[0];
      old_mode = m_mode;
      case (m_state)
         0: if (m_edge - m_entered == HOLD) begin m_state = 1; m_entered = m_edge; end
         1: if (old_mode) begin m_state = 3; m_target = 1'b1; m_entered = m_edge; end
         2: if (!old_mode) begin m_state = 3; m_target = 1'b0; m_entered = m_edge; end
         default: if (m_edge - m_entered == HOLD) begin
            m_state   = m_target ? 2 : 1;
            m_entered = m_edge;
         end
      endcase
      // accept after DEB consecutive synced samples that all disagree with the mode
      shist.push_back(old_sync);
      if (shist.size() > DEB) void'(shist.pop_front());
      if (shist.size() == DEB) begin
         all_diff = 1'b1;
         foreach (shist[i]) if (shist[i] == m_mode) all_diff = 1'b0;
         if (all_diff) begin
            m_mode = !m_mode;
            shist.delete();
         end
      end
      mpipe.push_back(mode_pin);
      void'(mpipe.pop_front());
      rpipe.push_back(uart_rx);
      void'(rpipe.pop_front());
   endtask

   // driver tasks
   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // scoreboard against the model
   task automatic check_model();
      logic [1:0] sync_rx;
      logic [1:0] exp_crx;
      logic       exp_prx;
      logic       exp_core;
      sync_rx  = rpipe[0];
      exp_crx  = sync_rx;
      if (m_state == 2 || m_state == 3) exp_crx[0] = 1'b1;
      exp_prx  = (m_state == 2) ? sync_rx[0] : 1'b1;
      exp_core = (m_state == 1);
      check("state", 32'(state), 32'(m_state));
      check("core_reset_n", 32'(core_rst_n), 32'(exp_core));
      check("prog_reset_n", 32'(prog_rst_n), 32'(m_state == 2));
      check("prog_enable", 32'(prog_en), 32'(m_state == 2));
      check("busy", 32'(busy), 32'(m_state == 0 || m_state == 3));
      check("qspi_pad_oen", 32'(qspi_pad), 32'(exp_core ? qspi_oen : 4'hF));
      check("core_uart_rx", 32'(core_rx), 32'(exp_crx));
      check("prog_rx", 32'(prog_rx), 32'(exp_prx));
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) begin
         uart_rx  = 2'($urandom_range(0, 3));
         qspi_oen = 4'($urandom_range(0, 15));
         tick();
         check_model();
      end
   endtask

   typedef struct {
      logic       rst_n;
      logic       mode;
      logic [1:0] rx;
      logic [3:0] oen;
      logic [1:0] e_state;
      logic       e_core_rst_n;
      logic       e_prog_rst_n;
      logic       e_prog_en;
      logic       e_busy;
      logic [3:0] e_qspi;
      logic [1:0] e_core_rx;
      logic       e_prog_rx;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int dur;
      reset_n  = 1'b0;
      mode_pin = 1'b0;
      uart_rx  = 2'b00;
      qspi_oen = 4'b0101;
      model_reset_pipes();

      // reset hold and release with mode pin low
      vecs[0] = '{1'b0, 1'b0, 2'b00, 4'b0101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF,    2'b11, 1'b1};
      vecs[1] = '{1'b0, 1'b0, 2'b00, 4'b0101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF,    2'b11, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 2'b00, 4'b0101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF,    2'b11, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 2'b00, 4'b0101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF,    2'b00, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 2'b01, 4'b0101, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF,    2'b00, 1'b1};
      vecs[5] = '{1'b1, 1'b0, 2'b01, 4'b0101, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 2'b01, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 2'b10, 4'b1010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 2'b01, 1'b1};
      vecs[7] = '{1'b1, 1'b0, 2'b10, 4'b1010, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1010, 2'b10, 1'b1};

      for (int v = 0; v < 8; v++) begin
         reset_n  = vecs[v].rst_n;
         mode_pin = vecs[v].mode;
         uart_rx  = vecs[v].rx;
         qspi_oen = vecs[v].oen;
         tick();
         check("vec_state", 32'(state), 32'(vecs[v].e_state));
         check("vec_core_reset_n", 32'(core_rst_n), 32'(vecs[v].e_core_rst_n));
         check("vec_prog_reset_n", 32'(prog_rst_n), 32'(vecs[v].e_prog_rst_n));
         check("vec_prog_enable", 32'(prog_en), 32'(vecs[v].e_prog_en));
         check("vec_busy", 32'(busy), 32'(vecs[v].e_busy));
         check("vec_qspi", 32'(qspi_pad), 32'(vecs[v].e_qspi));
         check("vec_core_rx", 32'(core_rx), 32'(vecs[v].e_core_rx));
         check("vec_prog_rx", 32'(prog_rx), 32'(vecs[v].e_prog_rx));
      end

      // 5-cycle glitch in CORE_RUN is ignored
      mode_pin = 1'b1;
      step_n(5);
      mode_pin = 1'b0;
      step_n(20);
      check("glitch_state", 32'(state), 32'd1);
      check("glitch_core_reset_n", 32'(core_rst_n), 32'd1);

      // permanent raise: accepted at edge 10, hold 11..14, PROG_RUN at 15
      mode_pin = 1'b1;
      step_n(10);
      check("raise_state_e10", 32'(state), 32'd1);
      step_n(1);
      check("raise_state_e11", 32'(state), 32'd3);
      check("raise_core_reset_e11", 32'(core_rst_n), 32'd0);
      check("raise_busy_e11", 32'(busy), 32'd1);
      step_n(3);
      check("raise_state_e14", 32'(state), 32'd3);
      step_n(1);
      check("raise_state_e15", 32'(state), 32'd2);
      check("raise_prog_en", 32'(prog_en), 32'd1);
      check("raise_prog_reset_n", 32'(prog_rst_n), 32'd1);
      check("raise_qspi", 32'(qspi_pad), 32'hF);
      step_n(8);
      check("prog_core_rx0_idle", 32'(core_rx[0]), 32'd1);

      // drop, then re-raise two cycles into the hold
      mode_pin = 1'b0;
      step_n(11);
      check("reraise_state_e11", 32'(state), 32'd3);
      step_n(1);
      mode_pin = 1'b1;
      step_n(3);
      check("reraise_state_e15", 32'(state), 32'd1);
      step_n(7);
      check("reraise_state_e22", 32'(state), 32'd1);
      step_n(1);
      check("reraise_state_e23", 32'(state), 32'd3);
      step_n(4);
      check("reraise_state_e27", 32'(state), 32'd2);

      // back to CORE_RUN
      mode_pin = 1'b0;
      step_n(15);
      check("drop_state_e15", 32'(state), 32'd1);

      // reset asserted for one cycle in the middle of SWITCH_HOLD
      mode_pin = 1'b1;
      step_n(12);
      check("midrst_pre_state", 32'(state), 32'd3);
      reset_n = 1'b0;
      step_n(1);
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_core_reset_n", 32'(core_rst_n), 32'd0);
      check("midrst_prog_reset_n", 32'(prog_rst_n), 32'd0);
      check("midrst_prog_en", 32'(prog_en), 32'd0);
      check("midrst_busy", 32'(busy), 32'd1);
      check("midrst_qspi", 32'(qspi_pad), 32'hF);
      reset_n = 1'b1;
      step_n(4);
      check("midrst_state_r4", 32'(state), 32'd1);
      step_n(6);
      check("midrst_state_r10", 32'(state), 32'd1);
      step_n(1);
      check("midrst_state_r11", 32'(state), 32'd3);
      step_n(3);
      check("midrst_state_r14", 32'(state), 32'd3);
      step_n(1);
      check("midrst_state_r15", 32'(state), 32'd2);

      // randomized run: mode pulses of 1..24 cycles, rare 1-cycle resets
      dur = 0;
      for (int c = 0; c < 3000; c++) begin
         if (dur == 0) begin
            mode_pin = ~mode_pin;
            dur = $urandom_range(1, 24);
         end
         dur--;
         reset_n = ($urandom_range(0, 299) != 0);
         step_n(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/soc_boot_ctrl.md
Name: soc_boot_ctrl

Overview:
- Parametrised boot/programmer-mode controller between SoC top-level pins and soc_top.
- Replaces the combinational programmer-mode muxing with a synchronised, debounced mode input.
- Sequences core and programmer resets through a hold-off state machine, and routes N UART RX lines so that programmer traffic never reaches the core.
- Forces QSPI pads to input while the core is held in reset.

Parameters:
- NUM_UART, 2: number of UART RX channels; channel 0 is shared with the programmer.
- SYNC_STAGES, 2: flop stages on every asynchronous input (mode pin and RX pins); minimum 2.
- DEBOUNCE_CYCLES, 1024: consecutive cycles the synchronised mode pin must differ from the accepted value before it is accepted; minimum 1.
- RESET_HOLD_CYCLES, 16: cycles core reset stays asserted around every mode transition; minimum 1.
- QSPI_WIDTH, 4: number of QSPI data pads.

Ports:
- clk_i, in, 1: single clock.
- reset_ni, in, 1: synchronous, active-low reset.
- programmer_mode_i, in, 1: raw asynchronous mode pin; 1 requests programmer mode.
- uart_rx_i, in, NUM_UART: raw asynchronous RX pins.
- core_uart_rx_o, out, NUM_UART: synchronised RX to core UARTs.
- programmer_rx_o, out, 1: synchronised RX to the UART programmer.
- core_reset_no, out, 1: registered active-low core reset.
- programmer_reset_no, out, 1: registered active-low programmer reset.
- programmer_enable_o, out, 1: registered programmer enable.
- busy_o, out, 1: high in any hold state.
- state_o, out, 2: current state encoding.
- qspi_oen_i, in, QSPI_WIDTH: core pad direction; 1 = input.
- qspi_pad_oen_o, out, QSPI_WIDTH: direction to the IO buffers.

Behaviour:
- Reset:
  - reset_ni=0 at a clk_i edge forces RST_HOLD.
  - Hold counter, debounce counter and accepted mode (mode_q) clear to 0.
  - Mode synchroniser clears to 0; RX synchronisers set to 1.
  - core_reset_no=0, programmer_reset_no=0, programmer_enable_o=0, busy_o=1.
  - Applies mid-transition with no exceptions.
- Synchronisers: SYNC_STAGES flops per input. Pin-to-sync latency is SYNC_STAGES cycles.
- Debounce:
  - If mode_sync != mode_q, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with mode_sync still != mode_q, mode_q <= mode_sync and the counter clears.
  - A pin change is accepted SYNC_STAGES+DEBOUNCE_CYCLES cycles after it occurs.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- States (state_o): RST_HOLD=0, CORE_RUN=1, PROG_RUN=2, SWITCH_HOLD=3.
  - RST_HOLD: hold counter counts; after RESET_HOLD_CYCLES cycles goes to CORE_RUN. mode_q is not examined here.
  - CORE_RUN: core_reset_no=1. If mode_q=1, go to SWITCH_HOLD with target=PROG.
  - PROG_RUN: programmer_reset_no=1, programmer_enable_o=1, core_reset_no=0. If mode_q=0, go to SWITCH_HOLD with target=CORE.
  - SWITCH_HOLD:
    - core_reset_no=0, programmer_reset_no=0, programmer_enable_o=0, all routed RX idle at 1.
    - Counts RESET_HOLD_CYCLES, then goes to the target state.
    - mode_q changes during the hold are not acted on until the target state is reached; the target state then re-evaluates on its first cycle.
- All control outputs are registered and decoded from the next state, so they change on the same edge as the state.
- RX routing:
  - Channels 1..NUM_UART-1: core_uart_rx_o[k]=rx_sync[k] always.
  - Channel 0: in CORE_RUN/RST_HOLD, core=rx_sync[0] and programmer=1. In PROG_RUN, core=1 and programmer=rx_sync[0]. In SWITCH_HOLD both are 1.
- QSPI: qspi_pad_oen_o = all-ones while core_reset_no=0, otherwise qspi_oen_i. This is combinational from the registered core_reset_no.
- busy_o = (state is RST_HOLD or SWITCH_HOLD).
- Counter widths are $clog2(max+1); no counter wraps.

Test Plan (overrides: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=4, NUM_UART=2):
- Release reset_ni with mode pin=0 -> core_reset_no rises on the 4th edge after release; state_o=1; busy_o=0; qspi_pad_oen_o follows qspi_oen_i only after core_reset_no=1.
- In CORE_RUN, raise mode pin permanently -> mode_q set 10 cycles later; state_o=3 for 4 cycles; then state_o=2, programmer_enable_o=1, programmer_reset_no=1. uart_rx_i[0] toggles appear only on programmer_rx_o; core_uart_rx_o[0]=1.
- In CORE_RUN, pulse mode pin high for 5 cycles -> no state change; counter clears; core_reset_no stays 1.
- In PROG_RUN, drop mode pin, then raise it again 2 cycles after SWITCH_HOLD entry -> 4-cycle hold completes to CORE_RUN; after debounce, a second SWITCH_HOLD leads back to PROG_RUN.
- Assert reset_ni low for 1 cycle mid SWITCH_HOLD -> next edge state_o=0, all control outputs 0, qspi_pad_oen_o=4'b1111; with the pin still high, PROG_RUN is re-entered after the reset hold plus debounce.
- uart_rx_i[1] toggles in every state -> core_uart_rx_o[1] follows with 2-cycle latency; never idled.
